// File: rtl/mssd_frame_ctrl.sv
// Frame controller for the push-button serial demux.
// Receives start bit, 2-bit port, 4-bit length N and N data bits, one bit per
// debounced rising edge of clkPB, and routes the data bits to the selected port.
module mssd_frame_ctrl #(
  parameter logic        START_BIT = 1'b0,
  parameter int unsigned DB_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SerIn,
  input  logic       clkPB,
  output logic [3:0] P,
  output logic       SerOut,
  output logic       SerOut_Valid,
  output logic       done,
  output logic [1:0] port_num,
  output logic [3:0] rem_cnt,
  output logic       busy
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPort = 3'd1;
  localparam logic [2:0] StLen  = 3'd2;
  localparam logic [2:0] StData = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  // Cycles after reset until the sync/filter pipeline reflects the real clkPB level.
  localparam int unsigned WarmLen = DB_CYCLES + 2;
  localparam int unsigned WarmW   = $clog2(WarmLen + 1);

  logic [1:0]       pb_sync_q;
  logic [1:0]       si_sync_q;
  logic             pb_stable;
  logic             pb_prev_q;
  logic [WarmW-1:0] warm_q;
  logic             pb_tick;
  logic             rx_bit;

  logic [2:0] state_q, state_d;
  logic [1:0] bit_idx_q, bit_idx_d;
  logic [1:0] port_q, port_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] p_q, p_d;
  logic       serout_q, serout_d;
  logic       valid_q, valid_d;

  // Two-stage synchronizers of equal depth keep the data bit aligned with its clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      pb_sync_q <= 2'b00;
      si_sync_q <= 2'b00;
    end else begin
      pb_sync_q <= {pb_sync_q[0], clkPB};
      si_sync_q <= {si_sync_q[0], SerIn};
    end
  end

  if (DB_CYCLES == 0) begin : g_no_filter
    assign pb_stable = pb_sync_q[1];
  end else begin : g_filter
    localparam int unsigned DbW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    logic           stable_q;
    logic [DbW-1:0] db_cnt_q;

    // Debounce: adopt the new level only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
      if (rst) begin
        stable_q <= 1'b0;
        db_cnt_q <= '0;
      end else if (pb_sync_q[1] == stable_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DbW'(DB_CYCLES - 1)) begin
        stable_q <= pb_sync_q[1];
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DbW'(1);
      end
    end

    assign pb_stable = stable_q;
  end

  // Edge history is pinned high while the pipeline refills, so a button held
  // through reset never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q    <= '0;
      pb_prev_q <= 1'b1;
    end else begin
      if (warm_q != WarmW'(WarmLen)) warm_q <= warm_q + WarmW'(1);
      pb_prev_q <= (warm_q == WarmW'(WarmLen)) ? pb_stable : 1'b1;
    end
  end

  assign pb_tick = pb_stable & ~pb_prev_q;
  assign rx_bit  = si_sync_q[1];

  // Frame FSM next-state: every field advance is gated by a bit tick.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    port_d    = port_q;
    rem_d     = rem_q;
    p_d       = p_q;
    serout_d  = serout_q;
    valid_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (pb_tick && (rx_bit == START_BIT)) begin
          state_d   = StPort;
          bit_idx_d = 2'd0;
        end
      end
      StPort: begin
        if (pb_tick) begin
          port_d    = {port_q[0], rx_bit};
          bit_idx_d = bit_idx_q + 2'd1;
          if (bit_idx_q == 2'd1) begin
            state_d   = StLen;
            bit_idx_d = 2'd0;
            p_d       = 4'b0001 << port_d;
          end
        end
      end
      StLen: begin
        if (pb_tick) begin
          rem_d     = {rem_q[2:0], rx_bit};
          bit_idx_d = bit_idx_q + 2'd1;
          if (bit_idx_q == 2'd3) begin
            bit_idx_d = 2'd0;
            state_d   = (rem_d == 4'd0) ? StDone : StData;
          end
        end
      end
      StData: begin
        if (pb_tick) begin
          serout_d = rx_bit;
          valid_d  = 1'b1;
          rem_d    = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = StDone;
        end
      end
      StDone: begin
        // Ticks here are dropped; the frame context is cleared on the way out.
        state_d = StIdle;
        p_d     = 4'b0000;
        port_d  = 2'd0;
        rem_d   = 4'd0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_idx_q <= 2'd0;
      port_q    <= 2'd0;
      rem_q     <= 4'd0;
      p_q       <= 4'b0000;
      serout_q  <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      port_q    <= port_d;
      rem_q     <= rem_d;
      p_q       <= p_d;
      serout_q  <= serout_d;
      valid_q   <= valid_d;
    end
  end

  assign P            = p_q;
  assign SerOut       = serout_q;
  assign SerOut_Valid = valid_q;
  assign done         = (state_q == StDone);
  assign port_num     = port_q;
  assign rem_cnt      = rem_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mssd_frame_ctrl.sv
// Scoreboard bench for mssd_frame_ctrl: one instance without debounce, one with DB_CYCLES=4.
module tb_mssd_frame_ctrl;

  typedef struct packed {
    logic       is_done;
    logic       dbit;
    logic [3:0] rem;
    logic [3:0] p;
    logic [1:0] port;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser_in = 1'b0;
  logic pb0 = 1'b0;
  logic pb4 = 1'b0;

  logic [3:0] p0, p4;
  logic       so0, so4, vld0, vld4, dn0, dn4, busy0, busy4;
  logic [1:0] port0, port4;
  logic [3:0] rem0, rem4;

  int   n_checks = 0;
  int   n_errors = 0;
  ev_t  q0[$];
  ev_t  q4[$];

  always #5 clk = ~clk;

  mssd_frame_ctrl #(.START_BIT(1'b0), .DB_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .SerIn(ser_in), .clkPB(pb0), .P(p0), .SerOut(so0),
    .SerOut_Valid(vld0), .done(dn0), .port_num(port0), .rem_cnt(rem0), .busy(busy0)
  );

  mssd_frame_ctrl #(.START_BIT(1'b0), .DB_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .SerIn(ser_in), .clkPB(pb4), .P(p4), .SerOut(so4),
    .SerOut_Valid(vld4), .done(dn4), .port_num(port4), .rem_cnt(rem4), .busy(busy4)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t strobe(input logic b, input logic [3:0] rem, input logic [3:0] p);
    ev_t e;
    e.is_done = 1'b0; e.dbit = b; e.rem = rem; e.p = p; e.port = 2'd0;
    return e;
  endfunction

  function automatic ev_t fin(input logic [1:0] port, input logic [3:0] p);
    ev_t e;
    e.is_done = 1'b1; e.dbit = 1'b0; e.rem = 4'd0; e.p = p; e.port = port;
    return e;
  endfunction

  // Pops the next expected event for one DUT and compares it with what it presents.
  task automatic pop_cmp(input bit sel4, input logic kind);
    ev_t   e;
    string who;
    int    depth;
    who   = sel4 ? "dut4" : "dut0";
    depth = sel4 ? q4.size() : q0.size();
    if (depth == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_unexpected: got %s, expected no output", who, kind ? "done" : "strobe");
      return;
    end
    if (sel4) e = q4.pop_front();
    else      e = q0.pop_front();
    check({who, "_kind"}, 8'(kind), 8'(e.is_done));
    if (!kind) check({who, "_serout"}, 8'(sel4 ? so4 : so0), 8'(e.dbit));
    check({who, "_rem"}, 8'(sel4 ? rem4 : rem0), 8'(e.rem));
    check({who, "_P"}, 8'(sel4 ? p4 : p0), 8'(e.p));
    if (kind) check({who, "_port"}, 8'(sel4 ? port4 : port0), 8'(e.port));
  endtask

  // Monitor: strobe is handled before done since both can share the last data cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (vld0) pop_cmp(1'b0, 1'b0);
      if (dn0)  pop_cmp(1'b0, 1'b1);
      if (vld4) pop_cmp(1'b1, 1'b0);
      if (dn4)  pop_cmp(1'b1, 1'b1);
    end
  end

  task automatic pulse(input bit sel4, input logic b, input int width, input int gap);
    @(posedge clk);
    #1;
    ser_in = b;
    if (sel4) pb4 = 1'b1;
    else      pb0 = 1'b1;
    repeat (width) @(posedge clk);
    #1;
    pb0 = 1'b0;
    pb4 = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  // Sends the low n bits of v, MSB first.
  task automatic tx(input bit sel4, input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) pulse(sel4, v[i], sel4 ? 6 : 1, sel4 ? 8 : 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal;
  end

  initial begin
    // Reset with the button held down.
    rst = 1'b1; pb0 = 1'b1; pb4 = 1'b1; ser_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_P", 8'(p0), 8'(0));
    check("rst_SerOut", 8'(so0), 8'(0));
    check("rst_valid", 8'(vld0), 8'(0));
    check("rst_done", 8'(dn0), 8'(0));
    check("rst_port", 8'(port0), 8'(0));
    check("rst_rem", 8'(rem0), 8'(0));
    check("rst_busy", 8'(busy0), 8'(0));
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      check("held_busy0", 8'(busy0), 8'(0));
      check("held_busy4", 8'(busy4), 8'(0));
    end
    pb0 = 1'b0; pb4 = 1'b0;
    repeat (12) @(posedge clk);

    // Port 2, N=3, data 101.
    q0.push_back(strobe(1'b1, 4'd2, 4'b0100));
    q0.push_back(strobe(1'b0, 4'd1, 4'b0100));
    q0.push_back(strobe(1'b1, 4'd0, 4'b0100));
    q0.push_back(fin(2'd2, 4'b0100));
    tx(1'b0, 16'd2, 3);
    #1;
    check("f1_P", 8'(p0), 8'(4'b0100));
    check("f1_port", 8'(port0), 8'(2));
    check("f1_busy", 8'(busy0), 8'(1));
    tx(1'b0, 16'd3, 4);
    #1;
    check("f1_rem_len", 8'(rem0), 8'(3));
    tx(1'b0, 16'd5, 3);
    #1;
    check("f1_busy_end", 8'(busy0), 8'(0));
    check("f1_P_end", 8'(p0), 8'(0));
    check("f1_port_end", 8'(port0), 8'(0));
    check("f1_rem_end", 8'(rem0), 8'(0));

    // Port 3, N=0: straight to done.
    q0.push_back(fin(2'd3, 4'b1000));
    tx(1'b0, 16'd3, 3);
    #1;
    check("f2_P", 8'(p0), 8'(4'b1000));
    tx(1'b0, 16'd0, 4);
    #1;
    check("f2_busy_end", 8'(busy0), 8'(0));
    check("f2_P_end", 8'(p0), 8'(0));

    // Non-start ticks in idle are ignored.
    for (int k = 0; k < 4; k++) begin
      tx(1'b0, 16'd1, 1);
      #1;
      check("idle_ones_busy", 8'(busy0), 8'(0));
    end
    q0.push_back(strobe(1'b0, 4'd1, 4'b0001));
    q0.push_back(strobe(1'b1, 4'd0, 4'b0001));
    q0.push_back(fin(2'd0, 4'b0001));
    tx(1'b0, 16'd9, 9);
    #1;
    check("f3_busy_end", 8'(busy0), 8'(0));

    // Reset in the middle of an N=9 frame.
    q0.push_back(strobe(1'b1, 4'd8, 4'b0100));
    q0.push_back(strobe(1'b1, 4'd7, 4'b0100));
    q0.push_back(strobe(1'b0, 4'd6, 4'b0100));
    q0.push_back(strobe(1'b1, 4'd5, 4'b0100));
    q0.push_back(strobe(1'b0, 4'd4, 4'b0100));
    tx(1'b0, 16'h053A, 12);
    #1;
    check("f4_rem_mid", 8'(rem0), 8'(4));
    check("f4_busy_mid", 8'(busy0), 8'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("f4_P_rst", 8'(p0), 8'(0));
    check("f4_rem_rst", 8'(rem0), 8'(0));
    check("f4_busy_rst", 8'(busy0), 8'(0));
    check("f4_port_rst", 8'(port0), 8'(0));
    repeat (4) @(posedge clk);
    q0.push_back(strobe(1'b1, 4'd0, 4'b0010));
    q0.push_back(fin(2'd1, 4'b0010));
    tx(1'b0, 16'h0023, 8);
    #1;
    check("f5_busy_end", 8'(busy0), 8'(0));

    // Debounced instance: short glitches never tick, a long press ticks once.
    repeat (10) @(posedge clk);
    pulse(1'b1, 1'b0, 2, 8);
    #1;
    check("db_glitch_busy", 8'(busy4), 8'(0));
    pulse(1'b1, 1'b0, 6, 8);
    #1;
    check("db_press_busy", 8'(busy4), 8'(1));
    pulse(1'b1, 1'b1, 2, 8);
    #1;
    check("db_glitch_port", 8'(port4), 8'(0));
    q4.push_back(strobe(1'b1, 4'd0, 4'b0010));
    q4.push_back(fin(2'd1, 4'b0010));
    tx(1'b1, 16'h0023, 7);
    #1;
    check("db_busy_end", 8'(busy4), 8'(0));

    repeat (5) @(posedge clk);
    check("dut0_pending", 8'(q0.size()), 8'(0));
    check("dut4_pending", 8'(q4.size()), 8'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
